// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the registered ALU slice.
//   - OPCODE_W : width of the operation select bus
//   - OP_*     : operation encodings decoded by alu_top
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_NAND = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_AVG  = 3'd7;

endpackage : alu_pkg

// File: rtl/alu_divider.sv
// ----------------------------------------------------------------------------
// alu_divider
//   Purely combinational restoring divider, one unrolled stage per quotient
//   bit (MSB first).
//   Ports:
//     dividend    in   WIDTH   unsigned dividend
//     divisor     in   WIDTH   unsigned divisor
//     quotient    out  WIDTH   dividend / divisor (0 when divisor == 0)
//     remainder   out  WIDTH   dividend % divisor (0 when divisor == 0)
//     div_by_zero out  1       divisor == 0
// ----------------------------------------------------------------------------
module alu_divider #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // partial[k] is the running remainder after k stages; it is always
    // strictly less than the divisor, so WIDTH bits are enough.
    logic [WIDTH-1:0] partial [0:WIDTH];
    logic [WIDTH-1:0] quo_bits;

    assign partial[0] = '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            logic [WIDTH:0]   shifted;
            logic [WIDTH-1:0] trial;
            logic             fits;

            // Bring down the next dividend bit.
            assign shifted = {partial[gi], dividend[WIDTH-1-gi]};
            assign fits    = (shifted >= {1'b0, divisor});
            // When the divisor fits, shifted - divisor < divisor, so the
            // modulo-2^WIDTH difference is exact.
            assign trial   = shifted[WIDTH-1:0] - divisor;

            assign quo_bits[WIDTH-1-gi] = fits;
            assign partial[gi+1]        = fits ? trial : shifted[WIDTH-1:0];
        end
    endgenerate

    assign div_by_zero = (divisor == '0);
    assign quotient    = div_by_zero ? '0 : quo_bits;
    assign remainder   = div_by_zero ? '0 : partial[WIDTH];

endmodule : alu_divider

// File: rtl/alu_top.sv
// ----------------------------------------------------------------------------
// alu_top
//   Registered 8-function ALU: add, sub, mul, div, nand, not, compare,
//   average. Combinational compute from A/B/opcode, captured every cycle,
//   so outputs reflect the inputs sampled at the previous rising edge.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        synchronous active-low reset (clears outputs)
//     A          in   WIDTH    operand A, unsigned
//     B          in   WIDTH    operand B, unsigned
//     opcode     in   3        operation select (alu_pkg::OP_*)
//     result     out  2*WIDTH  registered result
//     carry_out  out  1        registered carry / no-borrow / div-by-zero flag
// ----------------------------------------------------------------------------
module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [OPCODE_W-1:0]   opcode,
    output logic [2*WIDTH-1:0]    result,
    output logic                  carry_out
);

    localparam int RW = 2 * WIDTH;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [RW-1:0]    mul_prod;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_zero;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;

    logic [RW-1:0]    result_next;
    logic             carry_next;
    logic [RW-1:0]    result_reg;
    logic             carry_reg;

    // Shared arithmetic; the 5-bit sum also feeds AVG so it never overflows.
    assign add_sum  = {1'b0, A} + {1'b0, B};
    // Two's-complement subtract; the MSB is the "no borrow" flag (A >= B).
    assign sub_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign mul_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign cmp_eq = (A == B);
    assign cmp_gt = (A > B);
    assign cmp_lt = (A < B);

    alu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .dividend    (A),
        .divisor     (B),
        .quotient    (div_quo),
        .remainder   (div_rem),
        .div_by_zero (div_zero)
    );

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_next = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                carry_next  = add_sum[WIDTH];
            end
            OP_SUB: begin
                result_next = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                carry_next  = sub_diff[WIDTH];
            end
            OP_MUL: begin
                result_next = mul_prod;
            end
            OP_DIV: begin
                // Divider already zeroes quotient/remainder on B == 0.
                result_next = {div_rem, div_quo};
                carry_next  = div_zero;
            end
            OP_NAND: begin
                result_next = {{WIDTH{1'b0}}, ~(A & B)};
            end
            OP_NOT: begin
                result_next = {{WIDTH{1'b0}}, ~A};
            end
            OP_CMP: begin
                result_next = {{(RW-3){1'b0}}, cmp_lt, cmp_gt, cmp_eq};
            end
            OP_AVG: begin
                result_next = {{WIDTH{1'b0}}, add_sum[WIDTH:1]};
            end
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            carry_reg  <= 1'b0;
        end else begin
            result_reg <= result_next;
            carry_reg  <= carry_next;
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_reg;

endmodule : alu_top

// File: tb/tb_alu_top.sv
// ----------------------------------------------------------------------------
// tb_alu_top
//   Drives operand/opcode vectors on the falling edge, pushes the expected
//   {carry_out, result} into a scoreboard queue, and compares one cycle later
//   (just after the capturing rising edge).
// ----------------------------------------------------------------------------
module tb_alu_top;
    import alu_pkg::*;

    typedef struct {
        string      tag;
        logic [8:0] expected;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] opcode;
    logic [7:0] result;
    logic       carry_out;

    int tests_run    = 0;
    int tests_failed = 0;

    sb_entry_t sb_q[$];

    always #5 clk = ~clk;

    alu_top #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .result    (result),
        .carry_out (carry_out)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural reference: returns {carry, result[7:0]}.
    function automatic logic [8:0] alu_model(input logic [2:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        int ai = a;
        int bi = b;
        int s;
        logic [7:0] r = 8'h00;
        logic       c = 1'b0;
        case (op)
            3'd0: begin s = ai + bi; r = 8'(s % 16); c = (s >= 16); end
            3'd1: begin s = (ai - bi + 16) % 16; r = 8'(s); c = (ai >= bi); end
            3'd2: r = 8'(ai * bi);
            3'd3: begin
                if (bi == 0) begin
                    r = 8'h00; c = 1'b1;
                end else begin
                    r = 8'(((ai % bi) * 16) + (ai / bi));
                end
            end
            3'd4: r = {4'h0, ~(a & b)};
            3'd5: r = {4'h0, ~a};
            3'd6: r = (ai == bi) ? 8'h01 : ((ai > bi) ? 8'h02 : 8'h04);
            default: r = 8'((ai + bi) / 2);
        endcase
        return {c, r};
    endfunction

    task automatic drive(input string tag, input logic rst, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        sb_entry_t e;
        @(negedge clk);
        rst_n  = rst;
        opcode = op;
        A      = a;
        B      = b;
        e.tag      = tag;
        e.expected = rst ? alu_model(op, a, b) : 9'h000;
        sb_q.push_back(e);
    endtask

    task automatic drive_exp(input string tag, input logic [2:0] op,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [8:0] exp_val);
        sb_entry_t e;
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = op;
        A      = a;
        B      = b;
        e.tag      = tag;
        e.expected = exp_val;
        sb_q.push_back(e);
    endtask

    // Output checker: entries pushed at a falling edge are captured at the
    // following rising edge and compared shortly after it.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("[TB] %-10s op=%0d A=%h B=%h rst_n=%b -> result=%h carry=%b (exp %h/%b)",
                     e.tag, opcode, A, B, rst_n, result, carry_out,
                     e.expected[7:0], e.expected[8]);
            check_value(e.tag, {23'd0, carry_out, result}, {23'd0, e.expected});
        end
    end

    initial begin
        rst_n  = 1'b0;
        opcode = OP_ADD;
        A      = 4'h0;
        B      = 4'h0;

        // Reset state with a non-trivial op applied.
        drive("reset0", 1'b0, OP_ADD, 4'hF, 4'hF);
        drive("reset1", 1'b0, OP_MUL, 4'hF, 4'hF);

        // Directed vectors with hand-derived expectations.
        drive_exp("add_c0",   OP_ADD,  4'hC, 4'h3, {1'b0, 8'h0F});
        drive_exp("add_c1",   OP_ADD,  4'hF, 4'h1, {1'b1, 8'h00});
        drive_exp("sub_nb",   OP_SUB,  4'hF, 4'h1, {1'b1, 8'h0E});
        drive_exp("sub_brw",  OP_SUB,  4'h1, 4'hF, {1'b0, 8'h02});
        drive_exp("sub_eq",   OP_SUB,  4'h7, 4'h7, {1'b1, 8'h00});
        drive_exp("mul_a3",   OP_MUL,  4'hA, 4'h3, {1'b0, 8'h1E});
        drive_exp("mul_ff",   OP_MUL,  4'hF, 4'hF, {1'b0, 8'hE1});
        drive_exp("div_d3",   OP_DIV,  4'hD, 4'h3, {1'b0, 8'h14});
        drive_exp("div_zero", OP_DIV,  4'hF, 4'h0, {1'b1, 8'h00});
        drive_exp("div_f1",   OP_DIV,  4'hF, 4'h1, {1'b0, 8'h0F});
        drive_exp("div_lt",   OP_DIV,  4'h2, 4'h9, {1'b0, 8'h20});
        drive_exp("nand",     OP_NAND, 4'hA, 4'h5, {1'b0, 8'h0F});
        drive_exp("not",      OP_NOT,  4'hA, 4'h7, {1'b0, 8'h05});
        drive_exp("cmp_eq",   OP_CMP,  4'h9, 4'h9, {1'b0, 8'h01});
        drive_exp("cmp_gt",   OP_CMP,  4'h9, 4'h3, {1'b0, 8'h02});
        drive_exp("cmp_lt",   OP_CMP,  4'h3, 4'h9, {1'b0, 8'h04});
        drive_exp("avg",      OP_AVG,  4'hA, 4'h5, {1'b0, 8'h07});
        drive_exp("avg_ff",   OP_AVG,  4'hF, 4'hF, {1'b0, 8'h0F});

        // Mid-stream reset overrides the op; release resumes next cycle.
        drive("rst_hold", 1'b0, OP_MUL, 4'hF, 4'hF);
        drive_exp("rst_rel", OP_MUL, 4'hF, 4'hF, {1'b0, 8'hE1});

        // Exhaustive sweep of every opcode at corner operand values.
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] a;
                logic [3:0] b;
                a = (k[0]) ? 4'hF : 4'h0;
                b = (k[1]) ? 4'hF : 4'h0;
                drive("corner", 1'b1, 3'(op), a, b);
            end
        end

        // Random vectors.
        for (int i = 0; i < 200; i++) begin
            drive("random", 1'b1, 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Let the last entries drain, then confirm nothing was left unchecked.
        repeat (3) @(negedge clk);
        check_value("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_alu_top
